uart_transmitter: RTL and testbench

Serial UART transmitter that frames a parallel word as 1 start bit, WORD_SIZE data bits (LSB first), an optional parity bit and 1 stop bit on a single line `tx`. It is the transmit counterpart of the team's UART receiver: with default parameters its frames are bit-compatible with that receiver at the same PULSE_WIDTH. A one-word holding register behind a valid/ready handshake lets the upstream logic queue the next word while the current frame is on the line, so frames go out back-to-back with no idle gap.

---
 rtl/uart_transmitter.sv | 152 +++++++++++++++
 tb/tb_uart_transmitter.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_transmitter.sv
// UART transmitter: start bit, WORD_SIZE data bits LSB first, optional parity, one stop bit.
// A one-word holding register lets the next word queue so frames go out back-to-back.
module uart_transmitter #(
    parameter int unsigned WORD_SIZE   = 8,
    parameter int unsigned PULSE_WIDTH = 4,
    parameter int unsigned PARITY      = 0
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 in_valid,
    input  logic [WORD_SIZE-1:0] in_data,
    output logic                 in_ready,
    output logic                 tx,
    output logic                 busy
);

    localparam int unsigned CNT_W = ($clog2(PULSE_WIDTH) > 1) ? $clog2(PULSE_WIDTH) : 1;
    localparam int unsigned BIT_W = ($clog2(WORD_SIZE) > 1) ? $clog2(WORD_SIZE) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PULSE_WIDTH - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(WORD_SIZE - 1);
    localparam logic PAR_SEED = (PARITY == 2);
    localparam logic HAS_PAR  = (PARITY != 0);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } state_t;

    state_t               state, state_d;
    logic                 tx_d;
    logic                 hold_full, hold_full_d;
    logic [WORD_SIZE-1:0] hold_data, hold_data_d;
    logic [WORD_SIZE-1:0] sh, sh_d;
    logic [CNT_W-1:0]     clk_cnt, clk_cnt_d;
    logic [BIT_W-1:0]     bit_cnt, bit_cnt_d;
    logic                 par, par_d;
    logic                 bit_end;
    logic                 par_nxt;
    logic                 load;

    assign in_ready = !hold_full;
    assign busy     = (state != ST_IDLE);

    // State and datapath registers
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state     <= ST_IDLE;
            tx        <= 1'b1;
            hold_full <= 1'b0;
            hold_data <= '0;
            sh        <= '0;
            clk_cnt   <= '0;
            bit_cnt   <= '0;
            par       <= 1'b0;
        end else begin
            state     <= state_d;
            tx        <= tx_d;
            hold_full <= hold_full_d;
            hold_data <= hold_data_d;
            sh        <= sh_d;
            clk_cnt   <= clk_cnt_d;
            bit_cnt   <= bit_cnt_d;
            par       <= par_d;
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_d     = state;
        tx_d        = tx;
        hold_full_d = hold_full;
        hold_data_d = hold_data;
        sh_d        = sh;
        clk_cnt_d   = clk_cnt;
        bit_cnt_d   = bit_cnt;
        par_d       = par;

        bit_end = (clk_cnt == CNT_LAST);
        par_nxt = par ^ sh[0];
        load    = hold_full && ((state == ST_IDLE) || ((state == ST_STOP) && bit_end));

        if (in_valid && !hold_full) begin
            hold_full_d = 1'b1;
            hold_data_d = in_data;
        end

        if (state != ST_IDLE) begin
            clk_cnt_d = bit_end ? '0 : clk_cnt + CNT_W'(1);
        end

        case (state)
            ST_IDLE: begin
                tx_d = 1'b1;
            end
            ST_START: begin
                if (bit_end) begin
                    state_d   = ST_DATA;
                    tx_d      = sh[0];
                    bit_cnt_d = '0;
                end
            end
            ST_DATA: begin
                if (bit_end) begin
                    sh_d  = sh >> 1;
                    par_d = par_nxt;
                    if (bit_cnt == BIT_LAST) begin
                        if (HAS_PAR) begin
                            state_d = ST_PARITY;
                            tx_d    = par_nxt;
                        end else begin
                            state_d = ST_STOP;
                            tx_d    = 1'b1;
                        end
                    end else begin
                        bit_cnt_d = bit_cnt + BIT_W'(1);
                        tx_d      = sh[1];
                    end
                end
            end
            ST_PARITY: begin
                if (bit_end) begin
                    state_d = ST_STOP;
                    tx_d    = 1'b1;
                end
            end
            ST_STOP: begin
                if (bit_end) begin
                    state_d = ST_IDLE;
                    tx_d    = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                tx_d    = 1'b1;
            end
        endcase

        // Load the queued word from IDLE or straight out of the stop bit
        if (load) begin
            sh_d        = hold_data;
            hold_full_d = 1'b0;
            tx_d        = 1'b0;
            state_d     = ST_START;
            clk_cnt_d   = '0;
            par_d       = PAR_SEED;
        end
    end

endmodule

// File: tb/tb_uart_transmitter.sv
// Directed self-checking bench for uart_transmitter across default, parity and small configurations.
module tb_uart_transmitter;

    logic clk;
    logic rstn;
    int   sel;
    int   n_cmp;
    int   n_bad;

    logic       iv0, iv1, iv2, iv3;
    logic [7:0] id0, id1, id2;
    logic [4:0] id3;
    logic       rdy0, rdy1, rdy2, rdy3;
    logic       tx0, tx1, tx2, tx3;
    logic       bsy0, bsy1, bsy2, bsy3;
    logic       tx_s, rdy_s, bsy_s;

    uart_transmitter #(.WORD_SIZE(8), .PULSE_WIDTH(4), .PARITY(0)) dut (
        .clk(clk), .rstn(rstn), .in_valid(iv0), .in_data(id0),
        .in_ready(rdy0), .tx(tx0), .busy(bsy0));
    uart_transmitter #(.WORD_SIZE(8), .PULSE_WIDTH(4), .PARITY(1)) dut_even (
        .clk(clk), .rstn(rstn), .in_valid(iv1), .in_data(id1),
        .in_ready(rdy1), .tx(tx1), .busy(bsy1));
    uart_transmitter #(.WORD_SIZE(8), .PULSE_WIDTH(4), .PARITY(2)) dut_odd (
        .clk(clk), .rstn(rstn), .in_valid(iv2), .in_data(id2),
        .in_ready(rdy2), .tx(tx2), .busy(bsy2));
    uart_transmitter #(.WORD_SIZE(5), .PULSE_WIDTH(2), .PARITY(0)) dut_small (
        .clk(clk), .rstn(rstn), .in_valid(iv3), .in_data(id3),
        .in_ready(rdy3), .tx(tx3), .busy(bsy3));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        case (sel)
            1:       begin tx_s = tx1; rdy_s = rdy1; bsy_s = bsy1; end
            2:       begin tx_s = tx2; rdy_s = rdy2; bsy_s = bsy2; end
            3:       begin tx_s = tx3; rdy_s = rdy3; bsy_s = bsy3; end
            default: begin tx_s = tx0; rdy_s = rdy0; bsy_s = bsy0; end
        endcase
    end

    task automatic drive(input logic v, input logic [7:0] d);
        case (sel)
            1:       begin iv1 = v; id1 = d; end
            2:       begin iv2 = v; id2 = d; end
            3:       begin iv3 = v; id3 = d[4:0]; end
            default: begin iv0 = v; id0 = d; end
        endcase
    endtask

    // Sample tx/busy/in_ready of the selected DUT for n cycles, starting at the current negedge
    task automatic record(input int n, output logic [127:0] txv,
                          output logic [127:0] bv, output logic [127:0] rv);
        txv = '0; bv = '0; rv = '0;
        for (int i = 0; i < n; i++) begin
            txv[i] = tx_s;
            bv[i]  = bsy_s;
            rv[i]  = rdy_s;
            @(negedge clk);
        end
    endtask

    // Stretch a frame bit sequence (bit 0 = start bit) into per-cycle line levels
    function automatic logic [127:0] expand(input logic [31:0] seq, input int nb, input int pw);
        logic [127:0] r;
        r = '0;
        for (int i = 0; i < nb * pw; i++) r[i] = seq[i / pw];
        return r;
    endfunction

    function automatic logic [127:0] ones(input int n);
        logic [127:0] r;
        r = '0;
        for (int i = 0; i < n; i++) r[i] = 1'b1;
        return r;
    endfunction

    task automatic test_reset();
        sel = 0;
        repeat (3) @(negedge clk);
        n_cmp++; if (tx_s !== 1'b1) begin n_bad++; $display("FAIL reset_tx: got %b want 1", tx_s); end
        n_cmp++; if (rdy_s !== 1'b1) begin n_bad++; $display("FAIL reset_ready: got %b want 1", rdy_s); end
        n_cmp++; if (bsy_s !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", bsy_s); end
        rstn = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_frame_a5();
        logic [127:0] txv, bv, rv, exp;
        logic [7:0]   word;
        sel = 0;
        drive(1'b1, 8'hA5);
        @(negedge clk);
        drive(1'b0, 8'hA5);
        n_cmp++; if (rdy_s !== 1'b0) begin n_bad++; $display("FAIL a5_ready_after_accept: got %b want 0", rdy_s); end
        n_cmp++; if (bsy_s !== 1'b0) begin n_bad++; $display("FAIL a5_busy_latency: got %b want 0", bsy_s); end
        n_cmp++; if (tx_s !== 1'b1) begin n_bad++; $display("FAIL a5_tx_latency: got %b want 1", tx_s); end
        @(negedge clk);
        record(40, txv, bv, rv);
        exp = expand({1'b1, 8'hA5, 1'b0}, 10, 4);
        n_cmp++; if (txv !== exp) begin n_bad++; $display("FAIL a5_tx_wave: got %h want %h", txv, exp); end
        n_cmp++; if (bv !== ones(40)) begin n_bad++; $display("FAIL a5_busy_wave: got %h want %h", bv, ones(40)); end
        n_cmp++; if (rv !== ones(40)) begin n_bad++; $display("FAIL a5_ready_wave: got %h want %h", rv, ones(40)); end
        n_cmp++; if (bsy_s !== 1'b0) begin n_bad++; $display("FAIL a5_busy_end: got %b want 0", bsy_s); end
        n_cmp++; if (tx_s !== 1'b1) begin n_bad++; $display("FAIL a5_tx_end: got %b want 1", tx_s); end
        for (int b = 0; b < 8; b++) word[b] = txv[(b + 1) * 4 + 2];
        n_cmp++; if (word !== 8'hA5) begin n_bad++; $display("FAIL a5_decoded: got %h want a5", word); end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_back_to_back();
        logic [127:0] txv, bv, rv, exp, exp_r;
        sel = 0;
        drive(1'b1, 8'h00);
        @(negedge clk);
        n_cmp++; if (rdy_s !== 1'b0) begin n_bad++; $display("FAIL b2b_ready_queued: got %b want 0", rdy_s); end
        drive(1'b1, 8'hFF);
        @(negedge clk);
        n_cmp++; if (tx_s !== 1'b0) begin n_bad++; $display("FAIL b2b_start: got %b want 0", tx_s); end
        n_cmp++; if (rdy_s !== 1'b1) begin n_bad++; $display("FAIL b2b_ready_loaded: got %b want 1", rdy_s); end
        @(negedge clk);
        drive(1'b0, 8'hFF);
        record(79, txv, bv, rv);
        exp = (expand({1'b1, 8'h00, 1'b0}, 10, 4) | (expand({1'b1, 8'hFF, 1'b0}, 10, 4) << 40)) >> 1;
        exp_r = ones(79) & ~ones(39);
        n_cmp++; if (txv !== exp) begin n_bad++; $display("FAIL b2b_tx_wave: got %h want %h", txv, exp); end
        n_cmp++; if (bv !== ones(79)) begin n_bad++; $display("FAIL b2b_busy_wave: got %h want %h", bv, ones(79)); end
        n_cmp++; if (rv !== exp_r) begin n_bad++; $display("FAIL b2b_ready_wave: got %h want %h", rv, exp_r); end
        n_cmp++; if (bsy_s !== 1'b0) begin n_bad++; $display("FAIL b2b_busy_end: got %b want 0", bsy_s); end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_full_hold();
        logic [127:0] txv, rv, exp, exp_r;
        sel = 0;
        txv = '0; rv = '0;
        drive(1'b1, 8'h3C);
        @(negedge clk);
        drive(1'b1, 8'hC3);
        @(negedge clk);
        for (int k = 0; k < 120; k++) begin
            txv[k] = tx_s;
            rv[k]  = rdy_s;
            if (k == 1)  drive(1'b1, 8'h5A);
            if (k == 41) drive(1'b0, 8'h5A);
            @(negedge clk);
        end
        exp = expand({1'b1, 8'h3C, 1'b0}, 10, 4)
            | (expand({1'b1, 8'hC3, 1'b0}, 10, 4) << 40)
            | (expand({1'b1, 8'h5A, 1'b0}, 10, 4) << 80);
        exp_r = ones(1) | (ones(1) << 40) | (ones(40) << 80);
        n_cmp++; if (txv !== exp) begin n_bad++; $display("FAIL full_tx_wave: got %h want %h", txv, exp); end
        n_cmp++; if (rv !== exp_r) begin n_bad++; $display("FAIL full_ready_wave: got %h want %h", rv, exp_r); end
        n_cmp++; if (bsy_s !== 1'b0) begin n_bad++; $display("FAIL full_busy_end: got %b want 0", bsy_s); end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_parity();
        logic [127:0] txv, bv, rv, exp;
        sel = 1;
        drive(1'b1, 8'h07);
        @(negedge clk);
        drive(1'b0, 8'h07);
        @(negedge clk);
        record(44, txv, bv, rv);
        exp = expand({1'b1, 1'b1, 8'h07, 1'b0}, 11, 4);
        n_cmp++; if (txv !== exp) begin n_bad++; $display("FAIL even_tx_wave: got %h want %h", txv, exp); end
        n_cmp++; if (bv !== ones(44)) begin n_bad++; $display("FAIL even_busy_wave: got %h want %h", bv, ones(44)); end
        n_cmp++; if (bsy_s !== 1'b0) begin n_bad++; $display("FAIL even_busy_end: got %b want 0", bsy_s); end
        sel = 2;
        drive(1'b1, 8'h07);
        @(negedge clk);
        drive(1'b0, 8'h07);
        @(negedge clk);
        record(44, txv, bv, rv);
        exp = expand({1'b1, 1'b0, 8'h07, 1'b0}, 11, 4);
        n_cmp++; if (txv !== exp) begin n_bad++; $display("FAIL odd_tx_wave: got %h want %h", txv, exp); end
        n_cmp++; if (bv !== ones(44)) begin n_bad++; $display("FAIL odd_busy_wave: got %h want %h", bv, ones(44)); end
        n_cmp++; if (bsy_s !== 1'b0) begin n_bad++; $display("FAIL odd_busy_end: got %b want 0", bsy_s); end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_small();
        logic [127:0] txv, bv, rv, exp;
        sel = 3;
        drive(1'b1, 8'h13);
        @(negedge clk);
        drive(1'b0, 8'h13);
        @(negedge clk);
        record(14, txv, bv, rv);
        exp = expand({1'b1, 5'h13, 1'b0}, 7, 2);
        n_cmp++; if (txv !== exp) begin n_bad++; $display("FAIL small_tx_wave: got %h want %h", txv, exp); end
        n_cmp++; if (bv !== ones(14)) begin n_bad++; $display("FAIL small_busy_wave: got %h want %h", bv, ones(14)); end
        n_cmp++; if (bsy_s !== 1'b0) begin n_bad++; $display("FAIL small_busy_end: got %b want 0", bsy_s); end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset_midframe();
        logic [127:0] txv, bv, rv;
        sel = 0;
        drive(1'b1, 8'h00);
        @(negedge clk);
        drive(1'b1, 8'hAA);
        @(negedge clk);
        @(negedge clk);
        drive(1'b0, 8'hAA);
        repeat (10) @(negedge clk);
        n_cmp++; if (bsy_s !== 1'b1) begin n_bad++; $display("FAIL mid_busy_before: got %b want 1", bsy_s); end
        n_cmp++; if (tx_s !== 1'b0) begin n_bad++; $display("FAIL mid_tx_before: got %b want 0", tx_s); end
        n_cmp++; if (rdy_s !== 1'b0) begin n_bad++; $display("FAIL mid_ready_before: got %b want 0", rdy_s); end
        #1 rstn = 1'b0;
        #1;
        n_cmp++; if (tx_s !== 1'b1) begin n_bad++; $display("FAIL mid_tx_async: got %b want 1", tx_s); end
        n_cmp++; if (bsy_s !== 1'b0) begin n_bad++; $display("FAIL mid_busy_async: got %b want 0", bsy_s); end
        n_cmp++; if (rdy_s !== 1'b1) begin n_bad++; $display("FAIL mid_ready_async: got %b want 1", rdy_s); end
        @(negedge clk);
        rstn = 1'b1;
        record(50, txv, bv, rv);
        n_cmp++; if (bv !== '0) begin n_bad++; $display("FAIL mid_queued_discarded: got %h want 0", bv); end
        n_cmp++; if (txv !== ones(50)) begin n_bad++; $display("FAIL mid_tx_idle: got %h want %h", txv, ones(50)); end
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        sel   = 0;
        rstn  = 1'b0;
        iv0 = 1'b0; iv1 = 1'b0; iv2 = 1'b0; iv3 = 1'b0;
        id0 = '0; id1 = '0; id2 = '0; id3 = '0;
        test_reset();
        test_frame_a5();
        test_back_to_back();
        test_full_hold();
        test_parity();
        test_small();
        test_reset_midframe();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
